pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. Drives enable/flush of PC, IF/ID,
//  ID/EX, EX/MEM and MEM/WB registers from load-use hazards, EX-stage redirects
//  (branch/jump/stack return) and data-memory wait states. Also keeps hazard performance counters.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 26 ++
 rtl/pipeline_stall_ctrl_if.sv | 40 ++++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 16 +
 rtl/pipeline_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM state encoding and
// the bundle of register enable/flush controls with its canonical settings.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} stall_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } stall_ctrl_t;

    localparam stall_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam stall_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    // Whole front end plus EX/MEM held; a bubble drains into MEM/WB.
    localparam stall_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam stall_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam stall_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam stall_ctrl_t CTRL_ABORT    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs from the datapath and register enable/flush controls back to it.
interface pipeline_stall_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_redirect;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_en;
    logic                  id_ex_flush;
    logic                  ex_mem_en;
    logic                  ex_mem_flush;
    logic                  mem_wb_flush;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               ex_redirect, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               ex_redirect, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler: memory wait > EX redirect > load-use, plus a
// memory-timeout watchdog and saturating hazard performance counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                clk,
    input logic                rst,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] S_MEM_ERR  = MEM_ERR;

    logic [1:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_err_q, mem_err_nxt;
    logic              run_rules, redirect_taken, load_use;
    stall_ctrl_t       ctrl;

    assign load_use = bus.id_valid && bus.ex_mem_read &&
                      (bus.id_rs1 == bus.ex_rd ||
                       (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        ctrl           = CTRL_NORMAL;
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        mem_err_nxt    = mem_err_q;
        run_rules      = 1'b0;
        redirect_taken = 1'b0;

        if (rst) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        ctrl         = CTRL_FREEZE;
                        state_nxt    = S_MEM_WAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end else begin
                        run_rules = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    // Redirect is deliberately not sampled here: ID/EX is frozen, so it stays valid.
                    if (bus.mem_ready) begin
                        state_nxt = S_RUN;
                        run_rules = 1'b1;
                    end else begin
                        ctrl = CTRL_FREEZE;
                        if (wait_cnt == WAIT_LAST) begin
                            mem_err_nxt = 1'b1;
                            state_nxt   = S_MEM_ERR;
                        end else begin
                            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                S_MEM_ERR: begin
                    ctrl      = CTRL_ABORT;
                    state_nxt = S_RUN;
                end
                default: state_nxt = S_RUN;
            endcase

            if (run_rules) begin
                if (bus.ex_redirect) begin
                    ctrl           = CTRL_REDIRECT;
                    redirect_taken = 1'b1;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!rst && !ctrl.pc_en),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_taken),
        .count (bus.flush_cnt)
    );

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.ex_mem_flush = ctrl.ex_mem_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.mem_err      = mem_err_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; a second instance with 3-bit counters
// shares the same stimulus so counter saturation is reached in a few cycles.
module tb_pipeline_stall_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.REG_ADDR_W(3), .CNT_W(16)) bus ();
    pipeline_stall_ctrl_if #(.REG_ADDR_W(3), .CNT_W(3))  bus_s ();

    pipeline_stall_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipeline_stall_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(16), .CNT_W(3)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.id_valid    = bus.id_valid;
    assign bus_s.id_rs1      = bus.id_rs1;
    assign bus_s.id_rs2      = bus.id_rs2;
    assign bus_s.id_uses_rs2 = bus.id_uses_rs2;
    assign bus_s.ex_mem_read = bus.ex_mem_read;
    assign bus_s.ex_rd       = bus.ex_rd;
    assign bus_s.ex_redirect = bus.ex_redirect;
    assign bus_s.mem_req     = bus.mem_req;
    assign bus_s.mem_ready   = bus.mem_ready;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_flush}
    logic [7:0] ctrl;
    assign ctrl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                   bus.id_ex_flush, bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_flush};

    localparam logic [7:0] V_NORMAL   = 8'b1101_0100;
    localparam logic [7:0] V_RESET    = 8'b0010_1011;
    localparam logic [7:0] V_FREEZE   = 8'b0000_0001;
    localparam logic [7:0] V_REDIRECT = 8'b1111_1100;
    localparam logic [7:0] V_LOADUSE  = 8'b0001_1100;
    localparam logic [7:0] V_ABORT    = 8'b1101_0110;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_uses_rs2 = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_redirect = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    task automatic set_lu(input logic [2:0] rs1, input logic [2:0] rs2, input logic uses2,
                          input logic [2:0] rd, input logic valid);
        bus.id_valid    = valid;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs2 = uses2;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = rd;
    endtask

    // Advance one cycle: land on the next falling edge, then let comb outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", 32'(ctrl), 32'(V_RESET));
        check("reset_stall_cnt", 32'(bus.stall_cnt), 0);
        check("reset_flush_cnt", 32'(bus.flush_cnt), 0);
        check("reset_mem_err", 32'(bus.mem_err), 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ctrl", 32'(ctrl), 32'(V_NORMAL));

        // Load-use on rs1: one stall, then the bubble clears ex_mem_read.
        set_lu(3'd3, 3'd1, 1'b1, 3'd3, 1'b1);
        #1;
        check("lu_rs1_ctrl", 32'(ctrl), 32'(V_LOADUSE));
        step();
        check("lu_rs1_stall_cnt", 32'(bus.stall_cnt), 1);
        bus.ex_mem_read = 1'b0;
        #1;
        check("lu_bubble_ctrl", 32'(ctrl), 32'(V_NORMAL));

        // Load-use via rs2, and the no-hazard variants.
        set_lu(3'd2, 3'd3, 1'b1, 3'd3, 1'b1);
        #1;
        check("lu_rs2_ctrl", 32'(ctrl), 32'(V_LOADUSE));
        step();
        check("lu_rs2_stall_cnt", 32'(bus.stall_cnt), 2);
        set_lu(3'd2, 3'd3, 1'b0, 3'd3, 1'b1);
        #1;
        check("rs2_unused_ctrl", 32'(ctrl), 32'(V_NORMAL));
        set_lu(3'd3, 3'd3, 1'b1, 3'd3, 1'b0);
        #1;
        check("id_invalid_ctrl", 32'(ctrl), 32'(V_NORMAL));

        // Redirect overrides a simultaneous load-use.
        set_lu(3'd3, 3'd1, 1'b1, 3'd3, 1'b1);
        bus.ex_redirect = 1'b1;
        #1;
        check("redirect_ctrl", 32'(ctrl), 32'(V_REDIRECT));
        step();
        check("redirect_flush_cnt", 32'(bus.flush_cnt), 1);
        check("redirect_stall_cnt", 32'(bus.stall_cnt), 2);

        // Memory wait: three freeze cycles, redirect ignored while waiting, then release.
        clear_inputs();
        bus.mem_req = 1'b1;
        #1;
        check("mw_c1_ctrl", 32'(ctrl), 32'(V_FREEZE));
        step();
        check("mw_c2_ctrl", 32'(ctrl), 32'(V_FREEZE));
        step();
        bus.ex_redirect = 1'b1;
        #1;
        check("mw_c3_ctrl", 32'(ctrl), 32'(V_FREEZE));
        step();
        check("mw_ignored_flush_cnt", 32'(bus.flush_cnt), 1);
        check("mw_stall_cnt", 32'(bus.stall_cnt), 5);
        bus.mem_ready = 1'b1;
        #1;
        check("mw_release_ctrl", 32'(ctrl), 32'(V_REDIRECT));
        step();
        check("mw_release_flush_cnt", 32'(bus.flush_cnt), 2);
        check("mw_release_stall_cnt", 32'(bus.stall_cnt), 5);
        clear_inputs();
        #1;
        check("mw_after_ctrl", 32'(ctrl), 32'(V_NORMAL));

        // Timeout: 16 freeze cycles, one abort cycle, then RUN with sticky mem_err.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("to_freeze_%0d", i), 32'(ctrl), 32'(V_FREEZE));
            check($sformatf("to_err_low_%0d", i), 32'(bus.mem_err), 0);
            step();
        end
        bus.mem_req = 1'b0;
        #1;
        check("to_abort_ctrl", 32'(ctrl), 32'(V_ABORT));
        check("to_mem_err", 32'(bus.mem_err), 1);
        check("to_stall_cnt", 32'(bus.stall_cnt), 21);
        step();
        check("to_after_ctrl", 32'(ctrl), 32'(V_NORMAL));
        check("to_err_sticky", 32'(bus.mem_err), 1);
        check("small_stall_sat", 32'(bus_s.stall_cnt), 7);
        check("small_flush_cnt", 32'(bus_s.flush_cnt), 2);

        // Reset in the second MEM_WAIT cycle takes effect immediately.
        bus.mem_req = 1'b1;
        #1;
        step();
        check("rst_mw_c2_ctrl", 32'(ctrl), 32'(V_FREEZE));
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'(ctrl), 32'(V_RESET));
        check("rst_mid_mem_err", 32'(bus.mem_err), 0);
        check("rst_mid_stall_cnt", 32'(bus.stall_cnt), 0);
        check("rst_mid_flush_cnt", 32'(bus.flush_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_req = 1'b0;
        #1;
        check("rst_release_ctrl", 32'(ctrl), 32'(V_NORMAL));
        bus.mem_req = 1'b1;
        #1;
        check("rst_new_wait_ctrl", 32'(ctrl), 32'(V_FREEZE));
        step();
        bus.mem_ready = 1'b1;
        #1;
        check("rst_new_release_ctrl", 32'(ctrl), 32'(V_NORMAL));
        step();
        clear_inputs();
        check("rst_stall_cnt", 32'(bus.stall_cnt), 1);

        // Saturation on the 3-bit instance: 6 then 3 more stalls, held at 7.
        set_lu(3'd5, 3'd0, 1'b0, 3'd5, 1'b1);
        repeat (5) step();
        check("sat_small_stall_6", 32'(bus_s.stall_cnt), 6);
        repeat (3) step();
        check("sat_small_stall_hold", 32'(bus_s.stall_cnt), 7);
        check("sat_main_stall_9", 32'(bus.stall_cnt), 9);
        clear_inputs();
        bus.ex_redirect = 1'b1;
        repeat (9) step();
        check("sat_small_flush_hold", 32'(bus_s.flush_cnt), 7);
        check("sat_main_flush_9", 32'(bus.flush_cnt), 9);
        clear_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
